chunk_gen: RTL and testbench
============================

# chunk_gen

Upstream window generator for the 3x3 convolution stage. Accepts a raster-order `pixel_pkg::pixel_t` stream on an AXI-stream slave and buffers the two previous image rows in internal line buffers. Emits one `pixel_pkg::chunk_t` 3x3 neighbourhood per interior pixel on an AXI-stream master that feeds the convolution block directly.

## Interface
- `WIDTH`, default 640: pixels per image row. Minimum 3.
- `HEIGHT`, default 480: rows per frame. Minimum 3.
- `clk` input, 1 bit: the block's single clock. Everything is on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-low.
- `axis_i` `axis_if.slave`, data is `pixel_t` (24 bits: `red`/`grn`/`blu`, 8 bits each): input pixel stream in raster order. `ok` = `vld & rdy`.
- `axis_o` `axis_if.master`, data is `chunk_t` (3x3 `pixel_t`): output window stream.
- `last` output, 1 bit: present only with `CHUNK_GEN_LAST_EN`.

## Operation
- Counters `col` (0..WIDTH-1) and `row` (0..HEIGHT-1) advance on each `axis_i.ok`.
  - `col` wraps to 0 at WIDTH-1, and `row` then increments.
  - When `col`=WIDTH-1 and `row`=HEIGHT-1, both wrap to 0. The next pixel starts a new frame.
- Line buffers `lb_top[WIDTH]` and `lb_mid[WIDTH]` have combinational read and registered write.
  - On `ok` at column c: `lb_top[c] <= lb_mid[c]` and `lb_mid[c] <= axis_i.data`.
- Window registers `win[3][3]`:
  - Index `[i][j]`: i=0 is the oldest row (top), j=0 is the oldest column (left).
  - On `ok`, columns shift left (`win[i][0]<=win[i][1]`, `win[i][1]<=win[i][2]`).
  - The new right column is {`lb_top[col]`, `lb_mid[col]`, `axis_i.data`}.
- State machine, 2 states:
  - FILL: `row` < 2, no output. Moves to RUN on the `ok` that makes `row`=2.
  - RUN: output enabled. Returns to FILL on the frame-wrap `ok`.
- Emission rule: an `ok` in RUN with `col` >= 2 loads `axis_o.data <= ` the shifted window and sets `axis_o.vld`.
  - The emitted chunk's `[1][1]` is pixel (row-1, col-1).
  - Per frame: exactly (HEIGHT-2)*(WIDTH-2) chunks, no padding.
  - Edge windows spanning row wrap (`col` < 2) are never emitted.
- Output register holds a single entry.
  - `axis_i.rdy = !axis_o.vld | axis_o.rdy`.
  - `axis_o.vld` clears on an output handshake when no new chunk is loaded in the same cycle.
  - A simultaneous output handshake and new emission keeps `vld`=1 with the new data.
- Non-emitting accepted pixels (FILL, or `col` < 2) never alter `axis_o.data`/`vld` except through the clear rule above.
- Arithmetic: none on pixel data. Bits are passed unchanged.

## Timing
- Reset values:
  - `axis_o.vld`=0, `axis_o.data`=0, `last`=0.
  - `col`=`row`=0, state FILL, window registers 0.
  - Line buffer contents are don't-care; they are never emitted before being overwritten.
- Reset mid-frame: the partial frame is abandoned and any pending output is dropped. The first pixel after `rst` deasserts is treated as (0,0).
- Latency: the chunk is valid the cycle after the `ok` of its bottom-right pixel (row r, col c).
- Throughput: 1 pixel/cycle with `axis_o.rdy` held high.
- While `axis_o.vld`=1 and `axis_o.rdy`=0: `axis_o.data` is stable, `axis_i.rdy`=0, and counters and buffers are frozen.
- `axis_i.vld` low creates bubbles only. No internal state advances without `ok`.

## Configuration
- `CHUNK_GEN_LAST_EN` defined:
  - Adds output `last`, registered alongside `axis_o.data`.
  - `last`=1 exactly with the chunk whose `[1][1]` is pixel (HEIGHT-2, WIDTH-2).
  - `last` is held stable under backpressure like `data`, and cleared with `vld`.
- Not defined: the `last` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Basic frame.** WIDTH=4, HEIGHT=4, pixel k=0..15 with `red`=k, `grn`=0x40+k, `blu`=0x80+k; `rdy` held 1.
  - Expect exactly 4 chunks, with `[1][1].red` = 5, 6, 9, 10.
  - First chunk: `[0][0].red`=0, `[2][2].red`=10, `vld` rising the cycle after pixel 10 is accepted.
- **Backpressure.** Same stream, `axis_o.rdy`=0 for 5 cycles after the first chunk.
  - `axis_o.vld`=1 with data held at center 5; `axis_i.rdy`=0 throughout.
  - After release, remaining centers 6, 9, 10 arrive in order, with no loss or duplication.
- **Input bubbles.** `axis_i.vld` toggled 1,0,1,0.
  - Same 4 chunks with identical contents; chunk spacing follows accepted pixels only.
- **Back-to-back frames.** Two 4x4 frames, the second with k+16.
  - 8 chunks total; second-frame centers `red` = 21, 22, 25, 26.
  - No chunk mixes rows from the two frames.
- **Reset mid-frame.** `rst` asserted after 7 pixels are accepted, then a full 4x4 frame.
  - `vld`=0 immediately on assertion.
  - Exactly 4 chunks from the new frame only, first center `red`=5.
- **Last flag.** With `CHUNK_GEN_LAST_EN` defined, 4x4 frame.
  - `last`=1 only on the chunk with center 10; 0 on centers 5, 6, 9.

Source files
------------

// File: rtl/axis_if.sv
// axis_if: valid/ready stream bundle with a parameterised payload width.
// The master drives vld/data, the slave drives rdy; a transfer happens when vld & rdy.
interface axis_if #(
  parameter int DW = 24
);
  logic          vld;
  logic          rdy;
  logic [DW-1:0] data;

  modport master (output vld, output data, input rdy);
  modport slave  (input vld, input data, output rdy);
endinterface

// File: rtl/chunk_gen.sv
// chunk_gen: buffers two image rows and emits one 3x3 window per interior pixel.
// Define CHUNK_GEN_LAST_EN to add the end-of-frame `last` output.
package pixel_pkg;
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } pixel_t;

  // [i][j]: i=0 is the top (oldest) row, j=0 the left (oldest) column.
  typedef pixel_t [2:0][2:0] chunk_t;
endpackage

module chunk_gen
  import pixel_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic  clk,
  input  logic  rst,
  axis_if.slave  axis_i,
  axis_if.master axis_o
`ifdef CHUNK_GEN_LAST_EN
  ,
  output logic  last
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [0:0]    state;

  pixel_t lb_top [WIDTH];
  pixel_t lb_mid [WIDTH];

  chunk_t win;
  chunk_t win_next;
  pixel_t din;

  logic ok;
  logic emit;
  logic end_row;
  logic end_frame;

  assign din        = pixel_t'(axis_i.data);
  // The single output slot can take a new chunk only if it is empty or draining now.
  assign axis_i.rdy = !axis_o.vld || axis_o.rdy;
  assign ok         = axis_i.vld && axis_i.rdy;
  assign end_row    = (col == COL_LAST);
  assign end_frame  = end_row && (row == ROW_LAST);
  assign emit       = ok && (state == ST_RUN) && (col >= CW'(2));

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col   <= '0;
      row   <= '0;
      state <= ST_FILL;
    end else if (ok) begin
      if (end_row) begin
        col <= '0;
        row <= end_frame ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end

      if (end_frame) begin
        state <= ST_FILL;
      end else if (end_row && (row == RW'(1))) begin
        state <= ST_RUN;
      end
    end
  end

  // NOTE: line buffers carry no reset so they can map onto RAM; every entry is rewritten before it is read into an emitted window.
  always_ff @(posedge clk) begin
    if (ok) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= din;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    win_next = win;
    for (int i = 0; i < 3; i++) begin
      win_next[i][0] = win[i][1];
      win_next[i][1] = win[i][2];
    end
    win_next[0][2] = lb_top[col];
    win_next[1][2] = lb_mid[col];
    win_next[2][2] = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win         <= '0;
      axis_o.vld  <= 1'b0;
      axis_o.data <= '0;
    end else begin
      if (ok) begin
        win <= win_next;
      end

      if (emit) begin
        axis_o.vld  <= 1'b1;
        axis_o.data <= win_next;
      end else if (axis_o.rdy) begin
        axis_o.vld <= 1'b0;
      end
    end
  end

`ifdef CHUNK_GEN_LAST_EN
  // The bottom-right pixel of the frame closes the window centred on (HEIGHT-2, WIDTH-2).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b0;
    end else if (emit) begin
      last <= end_frame;
    end else if (axis_o.rdy) begin
      last <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_chunk_gen.sv
// tb_chunk_gen: directed table, corner-case sequences and random traffic for chunk_gen,
// scored against a frame-image reference model.
`timescale 1ns/1ps
module tb_chunk_gen;
  import pixel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int MAX_CYC = 2000;

  typedef struct {
    int k;
    bit vld;
    int center;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_if #(.DW($bits(pixel_t))) in_if ();
  axis_if #(.DW($bits(chunk_t))) out_if ();

`ifdef CHUNK_GEN_LAST_EN
  logic last;
`endif

  chunk_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk    (clk),
    .rst    (rst),
    .axis_i (in_if),
    .axis_o (out_if)
`ifdef CHUNK_GEN_LAST_EN
    ,
    .last   (last)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [215:0] act, input logic [215:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  function automatic pixel_t pix(input int k);
    pixel_t p;
    p.red = 8'(k);
    p.grn = 8'(8'h40 + k);
    p.blu = 8'(8'h80 + k);
    return p;
  endfunction

  // Reference model: the current frame as an image; a window is due whenever
  // a pixel at row>=2, col>=2 is accepted, made of the 3x3 block ending there.
  pixel_t img [H][W];
  int     m_row, m_col;
  chunk_t exp_q[$];
  bit     exp_last_q[$];
  int     rx_center[$];
  bit     rx_last[$];
  bit     pend_emit, prev_stall;
  chunk_t prev_data;
  chunk_t mon_c, mon_e;
  bit     mon_l;

  always @(negedge clk) begin
    if (!rst) begin
      m_row = 0;
      m_col = 0;
      exp_q.delete();
      exp_last_q.delete();
      pend_emit  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", out_if.vld, 1'b1);
        check("hold_data", out_if.data, prev_data);
      end
      if (out_if.vld && !out_if.rdy) check("stall_in_rdy", in_if.rdy, 1'b0);
      if (pend_emit) check("latency_vld", out_if.vld, 1'b1);
      pend_emit = 1'b0;

      if (out_if.vld && out_if.rdy) begin
        mon_c = out_if.data;
        rx_center.push_back(int'(mon_c[1][1].red));
        check("spurious_chunk", 216'(exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_l = exp_last_q.pop_front();
          check("chunk_data", mon_c, mon_e);
`ifdef CHUNK_GEN_LAST_EN
          check("chunk_last", last, mon_l);
          rx_last.push_back(last);
`endif
        end
      end

      if (in_if.vld && in_if.rdy) begin
        img[m_row][m_col] = pixel_t'(in_if.data);
        if (m_row >= 2 && m_col >= 2) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              mon_e[i][j] = img[m_row - 2 + i][m_col - 2 + j];
          exp_q.push_back(mon_e);
          exp_last_q.push_back(m_row == H - 1 && m_col == W - 1);
          pend_emit = 1'b1;
        end
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row++;
          if (m_row == H) m_row = 0;
        end
      end

      prev_stall = out_if.vld && !out_if.rdy;
      prev_data  = out_if.data;
    end
  end

  // Compares received centres against frames of the k-numbered stream (5,6,9,10 per frame).
  task automatic check_centers(input string name, input int base, input int frames);
    check({name, "_count"}, rx_center.size(), 4 * frames);
    for (int f = 0; f < frames; f++) begin
      for (int q = 0; q < 4; q++) begin
        int idx;
        int want;
        idx  = f * 4 + q;
        want = base + 16 * f + ((q < 2) ? 5 + q : 7 + q);
        if (idx < rx_center.size()) check({name, "_center"}, rx_center[idx], want);
`ifdef CHUNK_GEN_LAST_EN
        if (idx < rx_last.size()) check({name, "_last"}, rx_last[idx], q == 3);
`endif
      end
    end
    rx_center.delete();
    rx_last.delete();
  endtask

  // mode 0: steady input, 1: vld toggles 1,0,1,0, 2: random vld/rdy/data.
  task automatic send_pixels(input int n, input int base, input int mode, input bit bp);
    int     k = 0;
    int     cyc = 0;
    bit     acc;
    bit     bp_done = 1'b0;
    chunk_t c;
    while (k < n && cyc < MAX_CYC) begin
      if (bp && !bp_done && out_if.vld) begin
        out_if.rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          c = out_if.data;
          check("bp_vld", out_if.vld, 1'b1);
          check("bp_center", c[1][1].red, 8'(base + 5));
          check("bp_in_rdy", in_if.rdy, 1'b0);
          @(posedge clk); #1;
        end
        out_if.rdy = 1'b1;
        bp_done = 1'b1;
      end
      if (mode == 2) begin
        in_if.vld  = ($urandom_range(0, 3) != 0);
        in_if.data = 24'($urandom);
        out_if.rdy = ($urandom_range(0, 3) != 0);
      end else begin
        in_if.vld  = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
        in_if.data = pix(base + k);
      end
      @(negedge clk);
      acc = in_if.vld && in_if.rdy;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    check("send_in_time", cyc < MAX_CYC, 1'b1);
    in_if.vld  = 1'b0;
    out_if.rdy = 1'b1;
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle_vld"}, out_if.vld, 1'b0);
  endtask

  task automatic pulse_reset();
    in_if.vld = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_vld_low", out_if.vld, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  vec_t   vec [16];
  chunk_t c2;

  initial begin
    for (int i = 0; i < 16; i++) vec[i] = '{k: i, vld: 1'b0, center: 0};
    vec[10] = '{k: 10, vld: 1'b1, center: 5};
    vec[11] = '{k: 11, vld: 1'b1, center: 6};
    vec[14] = '{k: 14, vld: 1'b1, center: 9};
    vec[15] = '{k: 15, vld: 1'b1, center: 10};

    in_if.vld  = 1'b0;
    in_if.data = '0;
    out_if.rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vld", out_if.vld, 1'b0);
    check("reset_data", out_if.data, '0);
    check("reset_in_rdy", in_if.rdy, 1'b1);
`ifdef CHUNK_GEN_LAST_EN
    check("reset_last", last, 1'b0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic frame: one pixel per cycle, output state checked one cycle after each accept.
    for (int i = 0; i < 16; i++) begin
      in_if.vld  = 1'b1;
      in_if.data = pix(vec[i].k);
      @(posedge clk); #1;
      check($sformatf("basic_vld_after_k%0d", vec[i].k), out_if.vld, vec[i].vld);
      if (vec[i].vld) begin
        c2 = out_if.data;
        check($sformatf("basic_center_after_k%0d", vec[i].k), c2[1][1].red, 8'(vec[i].center));
      end
      if (vec[i].k == 10) begin
        c2 = out_if.data;
        check("basic_first_top_left", c2[0][0].red, 8'd0);
        check("basic_first_bottom_right", c2[2][2].red, 8'd10);
      end
    end
    in_if.vld = 1'b0;
    drain("basic");
    check_centers("basic", 0, 1);

    send_pixels(16, 0, 0, 1'b1);
    drain("backpressure");
    check_centers("backpressure", 0, 1);

    send_pixels(16, 0, 1, 1'b0);
    drain("bubbles");
    check_centers("bubbles", 0, 1);

    send_pixels(32, 0, 0, 1'b0);
    drain("b2b");
    check_centers("b2b", 0, 2);

    // Reset after 7 pixels of a frame that must leave no trace.
    send_pixels(7, 100, 0, 1'b0);
    pulse_reset();
    send_pixels(16, 0, 0, 1'b0);
    drain("rst7");
    check_centers("rst7", 0, 1);

    // Reset while a chunk is pending under backpressure: the chunk is dropped.
    send_pixels(11, 100, 0, 1'b0);
    out_if.rdy = 1'b0;
    check("pending_before_rst", out_if.vld, 1'b1);
    pulse_reset();
    out_if.rdy = 1'b1;
    rx_center.delete();
    rx_last.delete();
    send_pixels(16, 0, 0, 1'b0);
    drain("rst_pending");
    check_centers("rst_pending", 0, 1);

    send_pixels(4 * W * H, 0, 2, 1'b0);
    drain("random");
    check("random_chunk_count", rx_center.size(), 4 * (W - 2) * (H - 2));
    rx_center.delete();
    rx_last.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
